// File: rtl/regfile_multiport_if.sv
// Register-file access bundle: one write port, two read ports, and init/drop status.
interface regfile_multiport_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              reg_write_en;
    logic [ADDR_W-1:0] RegWriteAddr;
    logic [DATA_W-1:0] RegWriteData;
    logic [ADDR_W-1:0] RegReadAddr1;
    logic [ADDR_W-1:0] RegReadAddr2;
    logic [DATA_W-1:0] RegReadData1;
    logic [DATA_W-1:0] RegReadData2;
    logic              init_busy;
    logic              write_drop;

    modport master (
        output reg_write_en, RegWriteAddr, RegWriteData, RegReadAddr1, RegReadAddr2,
        input  RegReadData1, RegReadData2, init_busy, write_drop
    );

    modport slave (
        input  reg_write_en, RegWriteAddr, RegWriteData, RegReadAddr1, RegReadAddr2,
        output RegReadData1, RegReadData2, init_busy, write_drop
    );
endinterface

// File: rtl/regfile_multiport.sv
// 1W/2R register file with sequenced post-reset init (entry k <= k) and optional hardwired-zero entry 0.
// Optional macro REGFILE_WR_BYPASS_EN: same-cycle write-to-read forwarding on both read ports.
module regfile_multiport #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    regfile_multiport_if.slave  bus
);
    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              init_busy_q, init_busy_d;
    logic              write_drop_q, write_drop_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    logic wr_to_zero;

    assign wr_to_zero = (ZERO_REG != 0) && (bus.RegWriteAddr == '0);

    // Next-state, init sequencing and write-port arbitration
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        init_busy_d  = init_busy_q;
        write_drop_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = bus.RegWriteAddr;
        mem_wdata    = bus.RegWriteData;

        case (state_q)
            ST_INIT: begin
                mem_we       = 1'b1;
                mem_waddr    = init_ptr_q;
                mem_wdata    = DATA_W'(init_ptr_q);
                init_ptr_d   = ADDR_W'(init_ptr_q + 1'b1);
                write_drop_d = bus.reg_write_en;
                if (init_ptr_q == LAST_PTR) begin
                    state_d     = ST_READY;
                    init_busy_d = 1'b0;
                end
            end
            ST_READY: begin
                mem_we = bus.reg_write_en && !wr_to_zero;
            end
            default: begin
                state_d     = ST_INIT;
                init_ptr_d  = '0;
                init_busy_d = 1'b1;
            end
        endcase
    end

    // Control state; reset restarts the init sequence from entry 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            init_busy_q  <= 1'b1;
            write_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            init_busy_q  <= init_busy_d;
            write_drop_q <= write_drop_d;
        end
    end

    // Storage array: no reset of contents, nothing written during a reset cycle
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_addr[0] = bus.RegReadAddr1;
    assign rd_addr[1] = bus.RegReadAddr2;

    // Asynchronous read ports, gated to zero during init and for hardwired entry 0
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (!init_busy_q && !((ZERO_REG != 0) && (rd_addr[p] == '0))) begin
                rd_data[p] = mem_q[rd_addr[p]];
`ifdef REGFILE_WR_BYPASS_EN
                if (bus.reg_write_en && (rd_addr[p] == bus.RegWriteAddr)) begin
                    rd_data[p] = bus.RegWriteData;
                end
`endif
            end
        end
    end

    assign bus.RegReadData1 = rd_data[0];
    assign bus.RegReadData2 = rd_data[1];
    assign bus.init_busy    = init_busy_q;
    assign bus.write_drop   = write_drop_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: one ZERO_REG=1 and one ZERO_REG=0 instance driven in lockstep.
module tb_regfile_multiport;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    logic clk;
    logic reset;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;

    int total;
    int bad;
    int n;

    regfile_multiport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_z ();
    regfile_multiport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_n ();

    assign if_z.reg_write_en = we;
    assign if_z.RegWriteAddr = waddr;
    assign if_z.RegWriteData = wdata;
    assign if_z.RegReadAddr1 = raddr1;
    assign if_z.RegReadAddr2 = raddr2;
    assign if_n.reg_write_en = we;
    assign if_n.RegWriteAddr = waddr;
    assign if_n.RegWriteData = wdata;
    assign if_n.RegReadAddr1 = raddr1;
    assign if_n.RegReadAddr2 = raddr2;

    regfile_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (if_z)
    );

    regfile_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (if_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until init_busy falls on the ZERO_REG=1 instance, bounded
    task automatic count_init(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (if_z.init_busy && cnt < 20);
    endtask

    task automatic check_all_k(input string tag);
        for (int k = 0; k < 8; k++) begin
            raddr1 = ADDR_W'(k);
            raddr2 = ADDR_W'(7 - k);
            #1;
            check({tag, "_z_p1"}, 32'(if_z.RegReadData1), 32'(k));
            check({tag, "_z_p2"}, 32'(if_z.RegReadData2), 32'(7 - k));
            check({tag, "_n_p1"}, 32'(if_n.RegReadData1), 32'(k));
            check({tag, "_n_p2"}, 32'(if_n.RegReadData2), 32'(7 - k));
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = 3'd3;
        raddr2 = 3'd5;

        // Reset for two cycles
        step();
        step();
        check("rst_busy_z", 32'(if_z.init_busy), 32'd1);
        check("rst_busy_n", 32'(if_n.init_busy), 32'd1);
        check("rst_drop_z", 32'(if_z.write_drop), 32'd0);
        check("rst_rd1", 32'(if_z.RegReadData1), 32'd0);
        check("rst_rd2", 32'(if_n.RegReadData2), 32'd0);

        // Init: reads forced to 0 while busy, busy lasts exactly 8 edges
        reset = 1'b0;
        step();
        check("init_rd1_busy", 32'(if_z.RegReadData1), 32'd0);
        check("init_rd2_busy", 32'(if_n.RegReadData2), 32'd0);
        check("init_busy_1", 32'(if_z.init_busy), 32'd1);
        count_init(n);
        check("init_len", 32'(n + 1), 32'd8);
        check("init_done_n", 32'(if_n.init_busy), 32'd0);
        check_all_k("init_val");

        // Two writes, then both read ports simultaneously
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
        step();
        waddr = 3'd5; wdata = 8'h3C;
        step();
        we = 1'b0;
        raddr1 = 3'd3;
        raddr2 = 3'd5;
        #1;
        check("wr_a3", 32'(if_z.RegReadData1), 32'hA5);
        check("wr_a5", 32'(if_z.RegReadData2), 32'h3C);
        check("wr_a3_n", 32'(if_n.RegReadData1), 32'hA5);
        raddr1 = 3'd4;
        #1;
        check("wr_a4_kept", 32'(if_z.RegReadData1), 32'd4);
        check("wr_drop", 32'(if_z.write_drop), 32'd0);

        // Write 0xFF to address 0
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF;
        step();
        we = 1'b0;
        raddr1 = 3'd0;
        raddr2 = 3'd0;
        #1;
        check("zero_rd_z", 32'(if_z.RegReadData1), 32'h00);
        check("zero_rd2_z", 32'(if_z.RegReadData2), 32'h00);
        check("zero_drop_z", 32'(if_z.write_drop), 32'd0);
        check("zero_rd_n", 32'(if_n.RegReadData1), 32'hFF);
        check("zero_drop_n", 32'(if_n.write_drop), 32'd0);

        // Same-cycle write and read of address 6
        raddr1 = 3'd6;
        raddr2 = 3'd6;
        we = 1'b1; waddr = 3'd6; wdata = 8'h5A;
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        check("byp_p1", 32'(if_z.RegReadData1), 32'h5A);
        check("byp_p2", 32'(if_z.RegReadData2), 32'h5A);
        check("byp_p1_n", 32'(if_n.RegReadData1), 32'h5A);
`else
        check("byp_p1", 32'(if_z.RegReadData1), 32'h06);
        check("byp_p2", 32'(if_z.RegReadData2), 32'h06);
        check("byp_p1_n", 32'(if_n.RegReadData1), 32'h06);
`endif
        step();
        we = 1'b0;
        #1;
        check("byp_next_p1", 32'(if_z.RegReadData1), 32'h5A);
        check("byp_next_p2", 32'(if_z.RegReadData2), 32'h5A);

        // Write during init cycle 1 is dropped with a one-cycle pulse
        reset = 1'b1;
        step();
        reset = 1'b0;
        we = 1'b1; waddr = 3'd2; wdata = 8'h77;
        raddr1 = 3'd2;
        step();
        we = 1'b0;
        #1;
        check("drop_pulse_z", 32'(if_z.write_drop), 32'd1);
        check("drop_pulse_n", 32'(if_n.write_drop), 32'd1);
        check("drop_rd_busy", 32'(if_z.RegReadData1), 32'd0);
        step();
        check("drop_clear", 32'(if_z.write_drop), 32'd0);
        count_init(n);
        check("drop_init_len", 32'(n + 2), 32'd8);
        check("drop_a2_z", 32'(if_z.RegReadData1), 32'h02);
        check("drop_a2_n", 32'(if_n.RegReadData1), 32'h02);

        // Corrupt entries, then reset in the middle of init
        we = 1'b1; waddr = 3'd1; wdata = 8'hEE;
        step();
        waddr = 3'd7; wdata = 8'h99;
        step();
        we = 1'b0;
        raddr1 = 3'd7;
        #1;
        check("mid_pre_a7", 32'(if_z.RegReadData1), 32'h99);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("mid_rst_busy", 32'(if_z.init_busy), 32'd1);
        reset = 1'b0;
        count_init(n);
        check("mid_init_len", 32'(n), 32'd8);
        check("mid_done_n", 32'(if_n.init_busy), 32'd0);
        check_all_k("mid_val");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
